// File: rtl/hilo_div_seq.sv
// Issue sequencer for the combinational divider plus the HI/LO register pair.
// Holds the divide operands for DIV_LATENCY cycles, then captures the remainder into HI and the quotient into LO.
module hilo_div_seq #(
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_start,
  input  logic        div_sign,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  output logic [31:0] divu_a,
  output logic [31:0] divu_b,
  output logic        divu_sign,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  input  logic        mult_we,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        div_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;

  assign busy = (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (div_start) state_next = RUN;
      RUN:  if (cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      div_done  <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      divu_a    <= 32'd0;
      divu_b    <= 32'd0;
      divu_sign <= 1'b0;
    end else begin
      state    <= state_next;
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          // Priority: divide issue, then multiplier result, then MTHI/MTLO.
          if (div_start) begin
            divu_a    <= div_a;
            divu_b    <= div_b;
            divu_sign <= div_sign;
            cnt       <= 4'(DIV_LATENCY - 1);
          end else if (mult_we) begin
            hi <= mult_hi;
            lo <= mult_lo;
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        RUN: begin
          // Pipeline is stalled here, so any other write request is dropped.
          if (cnt == 4'd0) begin
            hi       <= divu_r;
            lo       <= divu_q;
            div_done <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
